// File: rtl/gf_poly_divider_if.sv
// Start/busy/done handshake bundle for the GF(2) polynomial divider.
interface gf_poly_divider_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                      start;
  logic [2*DATA_WIDTH-1:0]   dividend;
  logic [DATA_WIDTH:0]       poly;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic [DATA_WIDTH-1:0]     quotient;
  logic [DATA_WIDTH-1:0]     remainder;

  modport master (
    output start, dividend, poly,
    input  busy, done, err, quotient, remainder
  );

  modport slave (
    input  start, dividend, poly,
    output busy, done, err, quotient, remainder
  );
endinterface

// File: rtl/gf_poly_divider.sv
// Bit-serial carry-less long division of a 2m-bit product by a degree-m modulus over GF(2).
// Define GF_DIV_RADIX2_EN to retire two quotient bits per cycle instead of one.
module gf_poly_divider #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  gf_poly_divider_if.slave   bus
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned DW2 = 2 * DATA_WIDTH;
  localparam int unsigned CW  = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned IW  = $clog2(DW2);
`ifdef GF_DIV_RADIX2_EN
  localparam int unsigned STEPS = 2;
`else
  localparam int unsigned STEPS = 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_n;
  logic [DW2-1:0]   w_q, w_n;
  logic [DW:0]      p_q, p_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [DW-1:0]    q_q, q_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic [DW-1:0]    quo_q, quo_n;
  logic [DW-1:0]    rem_q, rem_n;

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_n;
      w_q     <= w_n;
      p_q     <= p_n;
      cnt_q   <= cnt_n;
      q_q     <= q_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      quo_q   <= quo_n;
      rem_q   <= rem_n;
    end
  end

  // Next-state, division steps and result capture
  always_comb begin
    logic [CW-1:0]  k;
    logic [IW-1:0]  bi;
    logic [DW2-1:0] wt;
    logic [DW-1:0]  qt;

    state_n = state_q;
    w_n     = w_q;
    p_n     = p_q;
    cnt_n   = cnt_q;
    q_n     = q_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    err_n   = err_q;
    quo_n   = quo_q;
    rem_n   = rem_q;
    k       = '0;
    bi      = '0;
    wt      = w_q;
    qt      = q_q;

    case (state_q)
      IDLE, DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        if (bus.start && !busy_q) begin
          state_n = RUN;
          w_n     = bus.dividend;
          p_n     = bus.poly;
          cnt_n   = CW'(DW - 1);
          q_n     = '0;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (!p_q[DW]) begin
          // Modulus without a leading term: report error without dividing
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          quo_n   = '0;
          rem_n   = '0;
        end else begin
          // Chain up to STEPS reductions, highest bit first
          for (int s = 0; s < int'(STEPS); s++) begin
            if (int'(cnt_q) >= s) begin
              k     = cnt_q - CW'(s);
              bi    = IW'(DW) + IW'(k);
              qt[k] = wt[bi];
              if (wt[bi]) wt = wt ^ (DW2'(p_q) << k);
            end
          end
          w_n = wt;
          q_n = qt;
          if (int'(cnt_q) < int'(STEPS)) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            err_n   = 1'b0;
            quo_n   = qt;
            rem_n   = wt[DW-1:0];
          end else begin
            cnt_n = cnt_q - CW'(STEPS);
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_gf_poly_divider.sv
// Self-checking bench for gf_poly_divider: directed cases plus randomized divisions
// checked against a search-by-multiplication reference.
module tb_gf_poly_divider;

  localparam int unsigned DW  = 4;
  localparam int unsigned DW2 = 2 * DW;
`ifdef GF_DIV_RADIX2_EN
  localparam int LAT = (DW + 1) / 2;
`else
  localparam int LAT = DW;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gf_poly_divider_if #(.DATA_WIDTH(DW)) bus ();

  gf_poly_divider #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: find the unique q with deg(q*poly ^ dividend) < DW
  function automatic void ref_div(input logic [DW2-1:0] dvd, input logic [DW:0] pl,
                                  output logic [DW-1:0] q, output logic [DW-1:0] r,
                                  output logic e);
    logic [DW2-1:0] prod;
    logic [DW2-1:0] diff;
    q = '0;
    r = '0;
    e = !pl[DW];
    if (!e) begin
      for (int c = 0; c < (1 << DW); c++) begin
        prod = '0;
        for (int j = 0; j < int'(DW); j++)
          if (c[j]) prod = prod ^ (DW2'(pl) << j);
        diff = prod ^ dvd;
        if ((diff >> DW) == '0) begin
          q = DW'(c);
          r = diff[DW-1:0];
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_results(input string tag, input logic [DW2-1:0] dvd, input logic [DW:0] pl);
    logic [DW-1:0] eq, er;
    logic          ee;
    ref_div(dvd, pl, eq, er, ee);
    check({tag, "_done"}, 32'(bus.done), 32'(1));
    check({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
    check({tag, "_rem"},  32'(bus.remainder), 32'(er));
    check({tag, "_err"},  32'(bus.err), 32'(ee));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'(0));
  endtask

  task automatic run_div(input string tag, input logic [DW2-1:0] dvd, input logic [DW:0] pl);
    int lat;
    logic [DW-1:0] qhold;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.poly     = pl;
    tick();
    bus.start    = 1'b0;
    bus.dividend = DW2'($urandom);
    bus.poly     = (DW + 1)'($urandom);
    check({tag, "_busy"}, 32'(bus.busy), 32'(1));
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), pl[DW] ? 32'(LAT) : 32'(1));
    check_results(tag, dvd, pl);
    qhold = bus.quotient;
    tick();
    check({tag, "_pulse"}, 32'(bus.done), 32'(0));
    check({tag, "_hold"}, 32'(bus.quotient), 32'(qhold));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat;
    int nd;
    logic [DW2-1:0] dvd;
    logic [DW:0]    pl;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.poly     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_err",  32'(bus.err),  32'(0));
    check("rst_quot", 32'(bus.quotient),  32'(0));
    check("rst_rem",  32'(bus.remainder), 32'(0));

    run_div("c1", 8'h78, 5'h13);
    check("c1_const_q", 32'(bus.quotient), 32'h7);
    check("c1_const_r", 32'(bus.remainder), 32'h1);
    run_div("c2a", 8'h2D, 5'h13);
    check("c2a_const_r", 32'(bus.remainder), 32'hB);
    run_div("c2b", 8'h4B, 5'h13);
    check("c2b_const_q", 32'(bus.quotient), 32'h4);
    run_div("c3", 8'hA5, 5'h03);
    run_div("small", 8'h0C, 5'h13);

    // Second start while busy must be ignored
    bus.start = 1'b1; bus.dividend = 8'h78; bus.poly = 5'h13;
    tick();
    bus.start = 1'b0;
    lat = 1;
    if (LAT > 2) begin
      tick();
      lat++;
    end
    bus.start = 1'b1; bus.dividend = 8'hFF;
    tick();
    bus.start = 1'b0;
    wait_done(nd);
    check("c4_lat", 32'(lat + nd), 32'(LAT));
    check_results("c4", 8'h78, 5'h13);
    tick();
    check("c4_no_restart", 32'(bus.busy), 32'(0));

    // Reset in the middle of a division
    bus.start = 1'b1; bus.dividend = 8'h78; bus.poly = 5'h13;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("c5_busy", 32'(bus.busy), 32'(0));
    check("c5_quot", 32'(bus.quotient), 32'(0));
    check("c5_rem",  32'(bus.remainder), 32'(0));
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) nd++;
      tick();
    end
    check("c5_no_done", 32'(nd), 32'(0));
    run_div("c5_after", 8'h4B, 5'h13);

    // Back-to-back with start held through the done cycle
    bus.start = 1'b1; bus.dividend = 8'h2D; bus.poly = 5'h13;
    tick();
    bus.dividend = 8'h4B;
    wait_done(lat);
    check("c6a_lat", 32'(lat), 32'(LAT));
    check_results("c6a", 8'h2D, 5'h13);
    tick();
    bus.start = 1'b0;
    check("c6_busy2", 32'(bus.busy), 32'(1));
    check("c6_hold", 32'(bus.remainder), 32'hB);
    wait_done(lat);
    check("c6b_lat", 32'(lat), 32'(LAT));
    check_results("c6b", 8'h4B, 5'h13);
    tick();

    for (int i = 0; i < 40; i++) begin
      dvd = DW2'($urandom);
      if ($urandom_range(0, 5) == 0) dvd = DW2'($urandom_range(0, (1 << DW) - 1));
      pl = {1'b1, DW'($urandom)};
      if ($urandom_range(0, 7) == 0) pl[DW] = 1'b0;
      run_div($sformatf("rnd%0d", i), dvd, pl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
